// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, lane widths
// and the byte-enable to bit-mask expansion also used by the MEM-stage store aligner.
package dmem_responder_pkg;

    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_BE_W   = 4;
    localparam int unsigned DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    function automatic logic [DMEM_DATA_W-1:0] be_to_mask(input logic [DMEM_BE_W-1:0] be);
        logic [DMEM_DATA_W-1:0] mask;
        for (int i = 0; i < DMEM_BE_W; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: asynchronous read, per-byte synchronous write.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DMEM_BE_W-1:0]   be,
    input  logic [IDX_W-1:0]       idx,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] rdata
);

    logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

    // NOTE: storage has no reset; clearing it would force flops instead of RAM
    // and nothing downstream relies on a known initial content.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DMEM_BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory target: accepts one request, waits WAIT_CYCLES, then
// returns load data / commits the store and flags faulting requests.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DMEM_DATA_W-1:0] req_wdata,
    input  logic [DMEM_BE_W-1:0]   req_be,
    output logic                   rsp_valid,
    output logic [DMEM_DATA_W-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   mem_stall
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD =
        DMEM_CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    dmem_state_e            state, state_next;
    logic [DMEM_CNT_W-1:0]  cnt, cnt_next;

    logic                   lat_write;
    logic [ADDR_W-1:0]      lat_addr;
    logic [DMEM_DATA_W-1:0] lat_wdata;
    logic [DMEM_BE_W-1:0]   lat_be;

    logic                   accept;
    logic                   in_resp;
    logic                   out_of_range;
    logic                   fault;
    logic                   commit;
    logic [DMEM_DATA_W-1:0] arr_rdata;

    assign accept = req_valid & req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DMEM_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            DMEM_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = DMEM_RESP;
                    end else begin
                        state_next = DMEM_WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            DMEM_WAIT: begin
                if (cnt == '0) begin
                    state_next = DMEM_RESP;
                end else begin
                    cnt_next = cnt - DMEM_CNT_W'(1);
                end
            end
            DMEM_RESP: state_next = DMEM_IDLE;
            default:   state_next = DMEM_IDLE;
        endcase
    end

    // Outputs are forced to their idle values while reset is held.
    assign in_resp      = rst_n & (state == DMEM_RESP);
    assign req_ready    = ~rst_n | (state == DMEM_IDLE);

    assign out_of_range = 64'(lat_addr[ADDR_W-1:2]) >= 64'(DEPTH_WORDS);
    assign fault        = (lat_addr[1:0] != 2'b00) | (lat_be == '0) | out_of_range;
    assign commit       = in_resp & lat_write & ~fault;

    assign rsp_valid = in_resp;
    assign rsp_err   = in_resp & fault;
    assign rsp_rdata = (in_resp & ~fault & ~lat_write) ? (arr_rdata & be_to_mask(lat_be)) : '0;
    assign mem_stall = req_valid & ~rsp_valid;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (commit),
        .be    (lat_be),
        .idx   (lat_addr[IDX_W+1:2]),
        .wdata (lat_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array model,
// plus a zero-wait-state instance for back-to-back request spacing.
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, req_ready, rsp_valid, rsp_err, mem_stall;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        z_valid, z_write, z_ready, z_rsp_valid, z_rsp_err, z_stall;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [3:0]  z_be;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mem_m [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_stall(mem_stall)
    );

    dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut_zero (
        .clk(clk), .rst_n(rst_n), .req_valid(z_valid), .req_ready(z_ready),
        .req_write(z_write), .req_addr(z_addr), .req_wdata(z_wdata), .req_be(z_be),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_rsp_err), .mem_stall(z_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit is_fault(input logic [31:0] a, input logic [3:0] be);
        return (a % 4 != 0) || (be == 4'b0000) || (a / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++)
            if (be[i]) r = r | (d & (32'hFF << (8 * i)));
        return r;
    endfunction

    // Called one time unit after a rising edge with the DUT idle.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input string tag,
                          output logic [31:0] rd_o, output logic err_o);
        bit          flt;
        logic [31:0] exp_rd;
        flt    = is_fault(addr, be);
        exp_rd = (wr || flt) ? 32'h0 : lanes(mem_m[addr / 4], be);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        #1;
        check({tag, ".ready_idle"}, req_ready, 1);
        check({tag, ".stall_idle"}, mem_stall, 1);
        @(posedge clk); #1;
        for (int k = 1; k <= W; k++) begin
            check({tag, ".wait_valid"}, rsp_valid, 0);
            check({tag, ".wait_ready"}, req_ready, 0);
            check({tag, ".wait_stall"}, mem_stall, 1);
            @(posedge clk); #1;
        end
        rd_o  = rsp_rdata;
        err_o = rsp_err;
        check({tag, ".rsp_valid"}, rsp_valid, 1);
        check({tag, ".rsp_err"},   rsp_err, 32'(flt));
        check({tag, ".rsp_rdata"}, rsp_rdata, exp_rd);
        check({tag, ".rsp_ready"}, req_ready, 0);
        check({tag, ".rsp_stall"}, mem_stall, 0);
        if (wr && !flt)
            mem_m[addr / 4] = (mem_m[addr / 4] & ~lanes(32'hFFFF_FFFF, be)) | lanes(wdata, be);
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        @(posedge clk); #1;
        check({tag, ".post_valid"}, rsp_valid, 0);
        check({tag, ".post_ready"}, req_ready, 1);
        check({tag, ".post_rdata"}, rsp_rdata, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, addr;
        logic        err;
        logic [3:0]  be;
        bit          wr;

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        z_valid = 1'b0; z_write = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.ready", req_ready, 1);
        check("reset.valid", rsp_valid, 0);
        check("reset.rdata", rsp_rdata, 0);
        check("reset.err",   rsp_err, 0);
        check("reset.stall", mem_stall, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle.ready", req_ready, 1);
        check("idle.valid", rsp_valid, 0);

        for (int i = 0; i < DEPTH; i++)
            do_req(1'b1, 32'(i * 4), $urandom, 4'hF, "fill", rd, err);

        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "st_beef", rd, err);
        check("st_beef.err", err, 0);
        check("st_beef.rdata", rd, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'hF, "ld_full", rd, err);
        check("ld_full.value", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h10, 32'h0, 4'b0011, "ld_half", rd, err);
        check("ld_half.value", rd, 32'h0000_BEEF);
        do_req(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, "st_byte", rd, err);
        do_req(1'b0, 32'h10, 32'h0, 4'hF, "ld_merged", rd, err);
        check("ld_merged.value", rd, 32'hDEAD_BEAA);

        do_req(1'b0, 32'h13, 32'h0, 4'hF, "ld_misalign", rd, err);
        check("ld_misalign.err", err, 1);
        check("ld_misalign.rdata", rd, 0);
        do_req(1'b1, 32'd4096, 32'h5555_5555, 4'hF, "st_oob", rd, err);
        check("st_oob.err", err, 1);
        do_req(1'b0, 32'h0, 32'h0, 4'hF, "ld_word0", rd, err);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, "ld_be0", rd, err);
        check("ld_be0.err", err, 1);
        do_req(1'b1, 32'(DEPTH * 4 - 4), 32'hA5A5_0F0F, 4'hF, "st_last", rd, err);
        check("st_last.err", err, 0);
        do_req(1'b0, 32'(DEPTH * 4 - 4), 32'h0, 4'hF, "ld_last", rd, err);
        check("ld_last.value", rd, 32'hA5A5_0F0F);

        // Reset during WAIT of a store: nothing may commit or respond.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_be = 4'hF;
        @(posedge clk); #1;
        check("rst_wait.valid", rsp_valid, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_wait.ready", req_ready, 1);
        check("rst_wait.no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rst_after.no_rsp", rsp_valid, 0);
            check("rst_after.ready", req_ready, 1);
        end
        do_req(1'b0, 32'h20, 32'h0, 4'hF, "rst_load", rd, err);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                2:       addr = 32'(DEPTH + $urandom_range(0, 63)) << 2;
                3, 4, 5: addr = 32'($urandom_range(0, 7)) << 2;
                default: addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            endcase
            be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            wr = 1'($urandom);
            do_req(wr, addr, $urandom, be, "rand", rd, err);
        end

        // Zero-wait instance: store, then loads with req_valid held continuously.
        z_valid = 1'b1; z_write = 1'b1; z_addr = 32'h4; z_wdata = 32'hCAFE_F00D; z_be = 4'hF;
        #1;
        check("z_store.ready", z_ready, 1);
        @(posedge clk); #1;
        check("z_store.valid", z_rsp_valid, 1);
        check("z_store.err", z_rsp_err, 0);
        z_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("z_b2b.valid", z_rsp_valid, 32'(i % 2));
            check("z_b2b.ready", z_ready, 32'(1 - i % 2));
            check("z_b2b.rdata", z_rdata, (i % 2 == 1) ? 32'hCAFE_F00D : 32'h0);
            check("z_b2b.stall", z_stall, 32'(1 - i % 2));
        end
        z_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the pipeline's MEM stage. The MEM stage initiates load/store requests; this block accepts them, inserts a configurable number of wait states, commits stores or returns load data, and reports faults.
- Drives mem_stall back to HZDPU so the pipeline holds MEM (and earlier stages) until the response.
- Sits between the future EX_MEM register and MEM_WB register.

Parameters:
- ADDR_W, 32, byte-address width of req_addr.
- DEPTH_WORDS, 1024, number of 32-bit words; word index = req_addr[ADDR_W-1:2].
- WAIT_CYCLES, 2, wait states between accept and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  MEM stage presents a request; held stable until rsp_valid.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, lane-aligned.
- req_be  in  4  byte-lane enables; bit i covers byte [8i+7:8i].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data; unselected lanes are 0.
- rsp_err  out  1  request faulted; valid only with rsp_valid.
- mem_stall  out  1  to HZDPU: req_valid & ~rsp_valid.

Behaviour:
- States:
  - IDLE.
  - WAIT: counts down WAIT_CYCLES.
  - RESP: one cycle.
- Reset (rst_n=0 at an edge): state=IDLE, counter=0, latched request cleared. Outputs while in reset/IDLE: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. The memory array is not cleared.
- req_ready=1 only in IDLE.
- Accept occurs when req_valid & req_ready at an edge. The block latches write/addr/wdata/be.
  - If WAIT_CYCLES=0, the next state is RESP.
  - Otherwise the next state is WAIT with counter=WAIT_CYCLES-1.
- WAIT: while counter≠0, decrement. When counter=0, go to RESP.
- Latency: rsp_valid is high exactly WAIT_CYCLES+1 cycles after the accept edge, for exactly one cycle.
- RESP → IDLE unconditionally. There is no response backpressure.
  - During RESP the MEM stage still presents the old request. Because req_ready=0, it is not re-accepted.
  - The minimum request spacing is WAIT_CYCLES+2 cycles.
- Fault detection (evaluated on latched request): rsp_err=1 if any of the following holds:
  - addr[1:0]≠0;
  - be=4'b0000;
  - word index ≥ DEPTH_WORDS.
- Faulted requests: no array write; rsp_rdata=0.
- Load (no fault): in RESP, rsp_rdata = array[index] masked by be (lane i forced to 0 if be[i]=0). The read is asynchronous from the latched index.
- Store (no fault):
  - Enabled lanes of wdata are written at the edge leaving RESP.
  - Disabled lanes are unchanged.
  - rsp_rdata=0.
- Outside RESP, rsp_rdata=0 and rsp_err=0.
- A load to the same address as the immediately previous store returns the stored data, because that store committed before the load was accepted.
- Reset mid-operation: if rst_n=0 at any edge before or at the RESP-exit edge, the pending store is not committed and no rsp_valid is produced.
- req_valid dropped before the response is illegal. Behaviour is defined anyway: the latched request still completes.
- mem_stall is combinational. It is 1 in IDLE with req_valid and throughout WAIT, and 0 in RESP.

Decomposition:
- Shared package holds:
  - state encoding constants DMEM_IDLE=2'd0, DMEM_WAIT=2'd1, DMEM_RESP=2'd2;
  - a width constant for byte-enable (4);
  - byte-lane mask expansion (be → 32-bit mask) as a function, reused by the future MEM-stage store aligner.
- One sub-module, dmem_array: DEPTH_WORDS×32 storage with asynchronous read, per-byte synchronous write enable, and no reset.
- The FSM, counter and fault logic remain in dmem_responder.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x10, be=4'hF, WAIT_CYCLES=2.
  - Expected: req_ready=0 for 3 cycles after accept; rsp_valid in cycle 3 with rsp_err=0; mem_stall high cycles 0–2.
- Load from 0x10, be=4'hF.
  - Expected: rsp_rdata=0xDEADBEEF.
- Load 0x10 with be=4'b0011.
  - Expected: 0x0000BEEF.
- Byte store 0x000000AA to 0x10, be=4'b0001, then load 0x10 full word.
  - Expected: 0xDEADBEAA.
- Faults:
  - Load at 0x13: rsp_err=1, rdata=0.
  - Store at byte address 4096 with DEPTH_WORDS=1024: rsp_err=1, and a subsequent load at 0x0 is unchanged.
  - be=0: rsp_err=1.
- Reset during WAIT of a store 0x12345678 to 0x20.
  - Expected: no rsp_valid, req_ready=1 after reset, and a load of 0x20 returns the prior value.
- WAIT_CYCLES=0 build, back-to-back loads held on req_valid.
  - Expected: rsp_valid every 2nd cycle, latency 1.
